// File: rtl/uvc_payload_packer_pkg.sv
// uvc_pkg: shared constants and types for the UVC payload packer.
//   UVC_HDR_LEN         - bytes of UVC payload header in front of pixel data
//   BFH_FID/EOF/EOH     - bit positions inside the header flags byte
//   state_t             - packer FSM state encoding
//   uvc_hdr_flags()     - builds the second header byte from eof/fid
package uvc_pkg;

   localparam int UVC_HDR_LEN = 2;

   localparam int BFH_FID = 0;
   localparam int BFH_EOF = 1;
   localparam int BFH_EOH = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_GAP,
      ST_WAIT,
      ST_HDR0,
      ST_HDR1,
      ST_DATA
   } state_t;

   function automatic logic [7:0] uvc_hdr_flags(input logic eof, input logic fid);
      logic [7:0] b;
      b          = 8'h00;
      b[BFH_EOH] = 1'b1;
      b[BFH_EOF] = eof;
      b[BFH_FID] = fid;
      return b;
   endfunction

endpackage

// File: rtl/uvc_payload_packer_if.sv
// uvc_payload_packer_if: bundles the frame-source fetch port (vf_*) and the
// payload byte stream (out_*).
//   master - packer side: drives vf_sof/vf_req and out_valid/out_data/out_last
//   slave  - source/sink side: drives vf_byte and out_ready
interface uvc_payload_packer_if;
   logic       vf_sof;
   logic       vf_req;
   logic [7:0] vf_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   modport master (
      output vf_sof, vf_req, out_valid, out_data, out_last,
      input  vf_byte, out_ready
   );

   modport slave (
      input  vf_sof, vf_req, out_valid, out_data, out_last,
      output vf_byte, out_ready
   );
endinterface

// File: rtl/uvc_payload_packer.sv
// uvc_payload_packer: pulls pixel bytes from a vf-interface frame source and
// emits UVC payloads (2-byte header + up to MAX_PAYLOAD-2 data bytes) on a
// valid/ready byte stream.
// Ports:
//   clk, rstn        - 60 MHz clock, async active-low reset
//   stream_en        - host streaming enable
//   pkt_req          - one-cycle request for a payload (honoured only in WAIT)
//   bus (master)     - vf_sof/vf_req/vf_byte and out_valid/ready/data/last
//   fid              - current UVC frame-ID bit
//   frame_done       - pulse on acceptance of the final byte of a frame
//
// state | meaning
// IDLE  | streaming off, waiting for stream_en
// SOF   | vf_sof pulse, frame byte counter loaded
// GAP   | source settling cycle after vf_sof
// WAIT  | frame in progress, waiting for pkt_req
// HDR0  | header length byte
// HDR1  | header flags byte (EOH, EOF, FID)
// DATA  | pixel bytes passed straight through from the source
module uvc_payload_packer
   import uvc_pkg::*;
#(
   parameter logic [13:0] FRAME_W     = 14'd252,
   parameter logic [13:0] FRAME_H     = 14'd120,
   parameter int          BPP         = 1,
   parameter int          MAX_PAYLOAD = 512
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   stream_en,
   input  logic                   pkt_req,
   uvc_payload_packer_if.master   bus,
   output logic                   fid,
   output logic                   frame_done
);

   localparam logic [31:0] FRAME_BYTES = 32'(FRAME_W) * 32'(FRAME_H) * 32'(BPP);
   localparam int          DATA_MAX    = MAX_PAYLOAD - UVC_HDR_LEN;
   localparam logic [10:0] DATA_MAX_L  = 11'(DATA_MAX);

   state_t      state, state_nxt;
   logic [31:0] remaining, remaining_nxt;
   logic [10:0] plen, plen_nxt;
   logic        fid_nxt;

   logic       vf_sof_c, vf_req_c, out_valid_c, out_last_c, frame_done_c;
   logic [7:0] out_data_c;
   logic       eof;

   assign eof = (remaining == {21'd0, plen});

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         remaining <= 32'd0;
         plen      <= 11'd0;
         fid       <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         plen      <= plen_nxt;
         fid       <= fid_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      plen_nxt      = plen;
      fid_nxt       = fid;
      vf_sof_c      = 1'b0;
      vf_req_c      = 1'b0;
      out_valid_c   = 1'b0;
      out_data_c    = 8'h00;
      out_last_c    = 1'b0;
      frame_done_c  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (stream_en) state_nxt = ST_SOF;
         end
         ST_SOF: begin
            vf_sof_c      = 1'b1;
            remaining_nxt = FRAME_BYTES;
            state_nxt     = ST_GAP;
         end
         ST_GAP: begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // Losing stream_en abandons the rest of the frame, even if a
            // request arrives in the same cycle.
            if (!stream_en) begin
               fid_nxt   = ~fid;
               state_nxt = ST_IDLE;
            end else if (pkt_req) begin
               plen_nxt  = (remaining < {21'd0, DATA_MAX_L}) ? remaining[10:0] : DATA_MAX_L;
               state_nxt = ST_HDR0;
            end
         end
         ST_HDR0: begin
            out_valid_c = 1'b1;
            out_data_c  = 8'(UVC_HDR_LEN);
            if (bus.out_ready) state_nxt = ST_HDR1;
         end
         ST_HDR1: begin
            out_valid_c = 1'b1;
            out_data_c  = uvc_hdr_flags(eof, fid);
            if (bus.out_ready) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            // The source holds vf_byte until vf_req, so tying vf_req to
            // out_ready keeps out_data stable across stalls.
            out_valid_c = 1'b1;
            out_data_c  = bus.vf_byte;
            vf_req_c    = bus.out_ready;
            out_last_c  = (plen == 11'd1);
            if (bus.out_ready) begin
               plen_nxt      = plen - 11'd1;
               remaining_nxt = remaining - 32'd1;
               if (out_last_c) begin
                  if (remaining == 32'd1) begin
                     frame_done_c = 1'b1;
                     fid_nxt      = ~fid;
                     state_nxt    = stream_en ? ST_SOF : ST_IDLE;
                  end else begin
                     state_nxt = ST_WAIT;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.vf_sof    = vf_sof_c;
   assign bus.vf_req    = vf_req_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_data_c;
   assign bus.out_last  = out_last_c;
   assign frame_done    = frame_done_c;

endmodule

// File: tb/tb_uvc_payload_packer.sv
// Bench for uvc_payload_packer: two instances (MONO 4x2/6-byte payloads and
// YUY2 4x2/8-byte payloads) fed by counting sources; payloads are checked
// against a frame/payload model built from the packing rules.
module tb_uvc_payload_packer;

   logic clk = 1'b0;
   logic rstn;
   logic stream_en_a, stream_en_b, pkt_a, pkt_b, rdy, sel;
   logic fid_a, fid_b, fd_a, fd_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uvc_payload_packer_if ifa ();
   uvc_payload_packer_if ifb ();

   uvc_payload_packer #(.FRAME_W(14'd4), .FRAME_H(14'd2), .BPP(1), .MAX_PAYLOAD(6)) dut_a (
      .clk(clk), .rstn(rstn), .stream_en(stream_en_a), .pkt_req(pkt_a),
      .bus(ifa), .fid(fid_a), .frame_done(fd_a)
   );

   uvc_payload_packer #(.FRAME_W(14'd4), .FRAME_H(14'd2), .BPP(2), .MAX_PAYLOAD(8)) dut_b (
      .clk(clk), .rstn(rstn), .stream_en(stream_en_b), .pkt_req(pkt_b),
      .bus(ifb), .fid(fid_b), .frame_done(fd_b)
   );

   // Counting sources: each frame starts at a new 0x40 boundary.
   logic [7:0] cnt_a, base_a, cnt_b, base_b;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_a <= 8'd0; base_a <= 8'hC0; cnt_b <= 8'd0; base_b <= 8'hC0;
      end else begin
         if (ifa.vf_sof) begin cnt_a <= 8'd0; base_a <= base_a + 8'h40; end
         else if (ifa.vf_req) cnt_a <= cnt_a + 8'd1;
         if (ifb.vf_sof) begin cnt_b <= 8'd0; base_b <= base_b + 8'h40; end
         else if (ifb.vf_req) cnt_b <= cnt_b + 8'd1;
      end
   end
   assign ifa.vf_byte   = base_a + cnt_a;
   assign ifb.vf_byte   = base_b + cnt_b;
   assign ifa.out_ready = rdy;
   assign ifb.out_ready = rdy;

   // Protocol monitors: sof/frame_done counts and vf_req too close to vf_sof.
   int sof_cnt_a = 0, sof_cnt_b = 0, fd_cnt_a = 0, fd_cnt_b = 0, viol_a = 0, viol_b = 0;
   int since_a = 99, since_b = 99;
   always @(posedge clk) begin
      if (ifa.vf_req && (ifa.vf_sof || since_a == 0)) viol_a <= viol_a + 1;
      if (ifb.vf_req && (ifb.vf_sof || since_b == 0)) viol_b <= viol_b + 1;
      since_a <= ifa.vf_sof ? 0 : (since_a < 99 ? since_a + 1 : 99);
      since_b <= ifb.vf_sof ? 0 : (since_b < 99 ? since_b + 1 : 99);
      if (ifa.vf_sof) sof_cnt_a <= sof_cnt_a + 1;
      if (ifb.vf_sof) sof_cnt_b <= sof_cnt_b + 1;
      if (fd_a) fd_cnt_a <= fd_cnt_a + 1;
      if (fd_b) fd_cnt_b <= fd_cnt_b + 1;
   end

   wire       m_valid = sel ? ifb.out_valid : ifa.out_valid;
   wire [7:0] m_data  = sel ? ifb.out_data  : ifa.out_data;
   wire       m_last  = sel ? ifb.out_last  : ifa.out_last;
   wire       m_req   = sel ? ifb.vf_req    : ifa.vf_req;
   wire       m_fd    = sel ? fd_b          : fd_a;

   logic [7:0] cap[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req_payload(input string tag);
      bit ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (sel) pkt_b = 1'b1; else pkt_a = 1'b1;
         @(negedge clk);
         pkt_a = 1'b0; pkt_b = 1'b0;
         #1;
         if (m_valid) ok = 1;
      end
      total++;
      if (!ok) begin
         bad++;
         $error("FAIL %s_req: observed=no_header expected=header_valid", tag);
      end
   endtask

   task automatic cap_payload(input string tag, input bit rnd, output int fd_seen);
      bit         stalled = 0, done = 0;
      logic [7:0] pd = 8'h00;
      logic       pl = 1'b0;
      int         n_acc = 0;
      cap.delete();
      fd_seen = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled) begin
            chk({tag, "_stall_data"}, 32'(m_data), 32'(pd));
            chk({tag, "_stall_last"}, 32'(m_last), 32'(pl));
         end
         chk({tag, "_vf_req"}, 32'(m_req), 32'((n_acc >= 2 && m_valid) ? rdy : 1'b0));
         if (m_valid && rdy) begin
            cap.push_back(m_data);
            n_acc++;
            if (m_fd) fd_seen++;
            if (m_last) done = 1;
         end
         stalled = m_valid && !rdy;
         pd = m_data;
         pl = m_last;
         if (!done) @(negedge clk);
      end
      total++;
      if (!done) begin
         bad++;
         $error("FAIL %s_timeout: observed=no_last expected=last_byte", tag);
      end
   endtask

   // Model: a frame of n bytes is cut into chunks of dmax; chunk starting at
   // byte 'start' carries header 02, flags(eof,fid) and source bytes.
   task automatic cmp_payload(input string tag, input int frame, input int start, input int n,
                              input int dmax, input bit fidv, input bit exp_fd, input int fd_seen);
      int         len;
      bit         eof;
      logic [7:0] e;
      len = (n - start < dmax) ? n - start : dmax;
      eof = (start + len == n);
      chk({tag, "_len"}, 32'(cap.size()), 32'(len + 2));
      for (int i = 0; i < cap.size() && i < len + 2; i++) begin
         if (i == 0)      e = 8'h02;
         else if (i == 1) e = {1'b1, 5'b0, eof, fidv};
         else             e = 8'(frame * 64 + start + i - 2);
         chk($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(e));
      end
      chk({tag, "_frame_done"}, 32'(fd_seen), 32'(exp_fd));
   endtask

   task automatic payload(input string tag, input int frame, input int start, input int n,
                          input int dmax, input bit fidv, input bit rnd, input bit exp_fd);
      int fds;
      req_payload(tag);
      cap_payload(tag, rnd, fds);
      cmp_payload(tag, frame, start, n, dmax, fidv, exp_fd, fds);
   endtask

   initial begin
      int fds;
      int sof_snap;
      rstn = 1'b0; stream_en_a = 1'b0; stream_en_b = 1'b0;
      pkt_a = 1'b0; pkt_b = 1'b0; rdy = 1'b0; sel = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", 32'(ifa.out_valid), 0);
      chk("rst_data",  32'(ifa.out_data),  0);
      chk("rst_last",  32'(ifa.out_last),  0);
      chk("rst_fid",   32'(fid_a),         0);
      chk("rst_sof",   32'(ifa.vf_sof),    0);
      chk("rst_req",   32'(ifa.vf_req),    0);
      chk("rst_fd",    32'(fd_a),          0);
      @(negedge clk);
      rstn = 1'b1;

      // Frame 0, always ready.
      stream_en_a = 1'b1;
      payload("f0p0", 0, 0, 8, 4, 1'b0, 1'b0, 1'b0);
      payload("f0p1", 0, 4, 8, 4, 1'b0, 1'b0, 1'b1);
      @(negedge clk); #1;
      chk("f0_fid", 32'(fid_a), 1);
      chk("f0_fd_cnt", 32'(fd_cnt_a), 1);
      chk("f0_sof_cnt", 32'(sof_cnt_a), 1);

      // Frame 1, random backpressure.
      payload("f1p0", 1, 0, 8, 4, 1'b1, 1'b1, 1'b0);
      payload("f1p1", 1, 4, 8, 4, 1'b1, 1'b1, 1'b1);
      @(negedge clk); #1;
      chk("f1_fid", 32'(fid_a), 0);
      chk("f1_fd_cnt", 32'(fd_cnt_a), 2);

      // Frame 2: stream_en drops during the first payload.
      req_payload("f2p0");
      stream_en_a = 1'b0;
      cap_payload("f2p0", 1'b0, fds);
      cmp_payload("f2p0", 2, 0, 8, 4, 1'b0, 1'b0, fds);
      repeat (3) @(negedge clk);
      #1;
      chk("drop_fid", 32'(fid_a), 1);
      chk("drop_valid", 32'(ifa.out_valid), 0);
      pkt_a = 1'b1;
      @(negedge clk);
      pkt_a = 1'b0;
      @(negedge clk); #1;
      chk("idle_pkt_ignored", 32'(ifa.out_valid), 0);
      chk("drop_sof_cnt", 32'(sof_cnt_a), 3);

      // Frame 3 restarts from a fresh source frame, then pkt_req collides
      // with stream_en falling in WAIT.
      stream_en_a = 1'b1;
      payload("f3p0", 3, 0, 8, 4, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      stream_en_a = 1'b0;
      pkt_a = 1'b1;
      @(negedge clk);
      pkt_a = 1'b0;
      #1;
      chk("collide_valid", 32'(ifa.out_valid), 0);
      chk("collide_fid", 32'(fid_a), 0);
      chk("collide_sof_cnt", 32'(sof_cnt_a), 4);

      // YUY2 instance: 16 bytes in payloads of 6, 6, 4.
      sel = 1'b1;
      stream_en_b = 1'b1;
      payload("b_p0", 0, 0,  16, 6, 1'b0, 1'b1, 1'b0);
      payload("b_p1", 0, 6,  16, 6, 1'b0, 1'b1, 1'b0);
      payload("b_p2", 0, 12, 16, 6, 1'b0, 1'b1, 1'b1);
      @(negedge clk); #1;
      chk("b_fd_cnt", 32'(fd_cnt_b), 1);
      chk("b_fid", 32'(fid_b), 1);

      // Reset in the middle of DATA.
      sel = 1'b0;
      stream_en_a = 1'b1;
      req_payload("rst_mid");
      rdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mid_pre_valid", 32'(ifa.out_valid), 1);
      rstn = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(ifa.out_valid), 0);
      chk("rst_mid_last",  32'(ifa.out_last),  0);
      chk("rst_mid_data",  32'(ifa.out_data),  0);
      chk("rst_mid_req",   32'(ifa.vf_req),    0);
      chk("rst_mid_fd",    32'(fd_a),          0);
      chk("rst_mid_fid_b", 32'(fid_b),         0);
      stream_en_a = 1'b0;
      stream_en_b = 1'b0;
      sof_snap = sof_cnt_a;
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("post_rst_valid", 32'(ifa.out_valid), 0);
      chk("post_rst_fid", 32'(fid_a), 0);
      chk("post_rst_idle_no_sof", 32'(sof_cnt_a), 32'(sof_snap));

      chk("vf_req_near_sof_a", 32'(viol_a), 0);
      chk("vf_req_near_sof_b", 32'(viol_b), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
